// File: rtl/counter_sweep_ctrl.sv
// Sweep controller: steps an external up/down counter to a commanded value, waits for it
// to settle, then checks the registered feedback and resyncs its shadow copy of the count.
module counter_sweep_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             pi_bClk,
    input  logic             pi_bReset,
    input  logic             pi_bCmdValid,
    output logic             po_bCmdReady,
    input  logic [WIDTH-1:0] pi_Target,
    input  logic             pi_bClearFirst,
    input  logic             pi_bShortest,
    input  logic [WIDTH-1:0] pi_Count,
    output logic             po_bCntReset,
    output logic             po_bCntEnable,
    output logic             po_bCntUpDown,
    output logic             po_bBusy,
    output logic             po_bDone,
    output logic             po_bMismatch
);

    // state  | meaning
    // IDLE   | ready for a command
    // CLEAR  | one-cycle counter reset, shadow zeroed at its end
    // RUN    | step toward target; one extra cycle once shadow == target
    // SETTLE | SETTLE_CYCLES wait, feedback compared on the last one
    // DONE   | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SETTLE,
        DONE
    } state_t;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] HALF        = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shadow, shadow_nxt;
    logic [WIDTH-1:0] target, target_nxt;
    logic             shortest, shortest_nxt;
    logic [SW-1:0]    settle_cnt, settle_cnt_nxt;
    logic             mismatch, mismatch_nxt;

    logic [WIDTH-1:0] dist_up;
    logic             at_target;
    logic             go_down;

    assign dist_up   = target - shadow;
    assign at_target = (shadow == target);

    // Shortest mode: an exact half-turn (dist_up == HALF) resolves upward.
    always_comb begin
        go_down = 1'b0;
        if (shortest) go_down = (dist_up > HALF);
        else          go_down = (target < shadow);
    end

    always_ff @(posedge pi_bClk) begin
        if (pi_bReset) begin
            state      <= IDLE;
            shadow     <= '0;
            target     <= '0;
            shortest   <= 1'b0;
            settle_cnt <= '0;
            mismatch   <= 1'b0;
        end else begin
            state      <= state_nxt;
            shadow     <= shadow_nxt;
            target     <= target_nxt;
            shortest   <= shortest_nxt;
            settle_cnt <= settle_cnt_nxt;
            mismatch   <= mismatch_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        shadow_nxt     = shadow;
        target_nxt     = target;
        shortest_nxt   = shortest;
        settle_cnt_nxt = settle_cnt;
        mismatch_nxt   = mismatch;
        case (state)
            IDLE: begin
                if (pi_bCmdValid) begin
                    target_nxt   = pi_Target;
                    shortest_nxt = pi_bShortest;
                    state_nxt    = pi_bClearFirst ? CLEAR : RUN;
                end
            end
            CLEAR: begin
                shadow_nxt = '0;
                state_nxt  = RUN;
            end
            RUN: begin
                if (at_target) begin
                    settle_cnt_nxt = SETTLE_LOAD;
                    state_nxt      = SETTLE;
                end else begin
                    shadow_nxt = go_down ? (shadow - ONE) : (shadow + ONE);
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    mismatch_nxt = (pi_Count != target);
                    shadow_nxt   = pi_Count;
                    state_nxt    = DONE;
                end else begin
                    settle_cnt_nxt = settle_cnt - SW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign po_bCmdReady  = (state == IDLE);
    assign po_bBusy      = (state == CLEAR) || (state == RUN) || (state == SETTLE);
    assign po_bDone      = (state == DONE);
    assign po_bCntEnable = (state == RUN) && !at_target;
    assign po_bCntUpDown = po_bCntEnable && go_down;
    assign po_bCntReset  = pi_bReset || (state == CLEAR);
    assign po_bMismatch  = mismatch;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl driving a behavioural up/down counter as feedback.
module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_target = '0;
    logic       clear_first = 1'b0;
    logic       shortest = 1'b0;
    logic [7:0] cnt = '0;
    logic       cnt_reset, en, ud, busy, done, mismatch;
    logic       glitch = 1'b0;

    int checks = 0;
    int failures = 0;

    counter_sweep_ctrl #(.WIDTH(8), .SETTLE_CYCLES(2)) dut (
        .pi_bClk       (clk),
        .pi_bReset     (rst),
        .pi_bCmdValid  (cmd_valid),
        .po_bCmdReady  (cmd_ready),
        .pi_Target     (cmd_target),
        .pi_bClearFirst(clear_first),
        .pi_bShortest  (shortest),
        .pi_Count      (cnt),
        .po_bCntReset  (cnt_reset),
        .po_bCntEnable (en),
        .po_bCntUpDown (ud),
        .po_bBusy      (busy),
        .po_bDone      (done),
        .po_bMismatch  (mismatch)
    );

    always #5 clk = ~clk;

    // Counter model; glitch injects a spurious extra up-step.
    always @(posedge clk) begin
        if (cnt_reset) cnt <= '0;
        else if (glitch) cnt <= cnt + 8'd1;
        else if (en) cnt <= ud ? cnt - 8'd1 : cnt + 8'd1;
    end

    // Issues one command from IDLE (cycle 0) and watches until the DONE cycle.
    task automatic run_cmd(input logic [7:0] tgt, input logic clr, input logic sh, input int glitch_at,
                           output int done_cyc, output int n_up, output int n_dn,
                           output int n_crst, output int crst_cyc, output int n_udbad);
        done_cyc = -1; n_up = 0; n_dn = 0; n_crst = 0; crst_cyc = -1; n_udbad = 0;
        cmd_valid = 1'b1; cmd_target = tgt; clear_first = clr; shortest = sh;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            glitch = (cyc == glitch_at);
            if (en) begin
                if (ud) n_dn++;
                else n_up++;
            end
            if (!en && ud) n_udbad++;
            if (cnt_reset) begin
                n_crst++;
                crst_cyc = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        glitch = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cnt_reset !== 1'b1) begin failures++; $display("FAIL reset_cntreset: got %b expected 1", cnt_reset); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, done, en, ud, mismatch, cnt_reset} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_outputs: got rdy,busy,done,en,ud,mm,crst=%b expected 1000000",
                     {cmd_ready, busy, done, en, ud, mismatch, cnt_reset});
        end
        checks++;
        if (cnt !== 8'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", cnt); end
    endtask

    task automatic test_linear_up();
        int dc, nu, nd, nc, cc, nb;
        run_cmd(8'd3, 1'b0, 1'b0, 0, dc, nu, nd, nc, cc, nb);
        checks++;
        if (dc !== 7) begin failures++; $display("FAIL lin_done_cycle: got %0d expected 7", dc); end
        checks++;
        if (nu !== 3 || nd !== 0) begin failures++; $display("FAIL lin_steps: got up=%0d dn=%0d expected up=3 dn=0", nu, nd); end
        checks++;
        if (nb !== 0 || nc !== 0) begin failures++; $display("FAIL lin_ud_crst: got udbad=%0d crst=%0d expected 0 0", nb, nc); end
        checks++;
        if (mismatch !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL lin_done_flags: got mm=%b busy=%b expected 0 0", mismatch, busy); end
        @(negedge clk);
        checks++;
        if (cnt !== 8'd3) begin failures++; $display("FAIL lin_count: got %0d expected 3", cnt); end
    endtask

    task automatic test_shortest_wrap();
        int dc, nu, nd, nc, cc, nb;
        run_cmd(8'd250, 1'b0, 1'b1, 0, dc, nu, nd, nc, cc, nb);
        checks++;
        if (dc !== 13) begin failures++; $display("FAIL wrap_done_cycle: got %0d expected 13", dc); end
        checks++;
        if (nu !== 0 || nd !== 9) begin failures++; $display("FAIL wrap_steps: got up=%0d dn=%0d expected up=0 dn=9", nu, nd); end
        checks++;
        if (nb !== 0) begin failures++; $display("FAIL wrap_ud_idle: got %0d expected 0", nb); end
        @(negedge clk);
        checks++;
        if (cnt !== 8'd250) begin failures++; $display("FAIL wrap_count: got %0d expected 250", cnt); end
    endtask

    task automatic test_clear_first();
        int dc, nu, nd, nc, cc, nb;
        run_cmd(8'd5, 1'b1, 1'b0, 0, dc, nu, nd, nc, cc, nb);
        checks++;
        if (nc !== 1 || cc !== 1) begin failures++; $display("FAIL clr_pulse: got n=%0d at=%0d expected n=1 at=1", nc, cc); end
        checks++;
        if (nu !== 5 || nd !== 0) begin failures++; $display("FAIL clr_steps: got up=%0d dn=%0d expected up=5 dn=0", nu, nd); end
        checks++;
        if (dc !== 10) begin failures++; $display("FAIL clr_done_cycle: got %0d expected 10", dc); end
        @(negedge clk);
        checks++;
        if (cnt !== 8'd5) begin failures++; $display("FAIL clr_count: got %0d expected 5", cnt); end
    endtask

    task automatic test_tie();
        int dc, nu, nd, nc, cc, nb;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_cmd(8'd128, 1'b0, 1'b1, 0, dc, nu, nd, nc, cc, nb);
        checks++;
        if (nu !== 128 || nd !== 0) begin failures++; $display("FAIL tie_steps: got up=%0d dn=%0d expected up=128 dn=0", nu, nd); end
        checks++;
        if (dc !== 132) begin failures++; $display("FAIL tie_done_cycle: got %0d expected 132", dc); end
        @(negedge clk);
        checks++;
        if (cnt !== 8'd128) begin failures++; $display("FAIL tie_count: got %0d expected 128", cnt); end
    endtask

    task automatic test_back_to_back();
        int dc, nu, nd, nc, cc, nb;
        // Feedback bumped by one during SETTLE: 128 -> 130 lands on 131.
        run_cmd(8'd130, 1'b0, 1'b0, 4, dc, nu, nd, nc, cc, nb);
        checks++;
        if (dc !== 6 || nu !== 2) begin failures++; $display("FAIL mm_run: got done=%0d up=%0d expected done=6 up=2", dc, nu); end
        checks++;
        if (mismatch !== 1'b1) begin failures++; $display("FAIL mm_set: got %b expected 1", mismatch); end
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL mm_ready_in_done: got %b expected 0", cmd_ready); end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || mismatch !== 1'b1 || cnt !== 8'd131) begin
            failures++;
            $display("FAIL mm_idle: got rdy=%b mm=%b cnt=%0d expected 1 1 131", cmd_ready, mismatch, cnt);
        end
        // Shadow resynced to 131, so the same target needs one down step.
        run_cmd(8'd130, 1'b0, 1'b0, 0, dc, nu, nd, nc, cc, nb);
        checks++;
        if (nd !== 1 || nu !== 0 || dc !== 5) begin
            failures++;
            $display("FAIL resync_steps: got dn=%0d up=%0d done=%0d expected 1 0 5", nd, nu, dc);
        end
        checks++;
        if (mismatch !== 1'b0) begin failures++; $display("FAIL resync_mm_clear: got %b expected 0", mismatch); end
        @(negedge clk);
        checks++;
        if (cnt !== 8'd130) begin failures++; $display("FAIL resync_count: got %0d expected 130", cnt); end
    endtask

    task automatic test_reset_mid_run();
        cmd_valid = 1'b1; cmd_target = 8'd135; clear_first = 1'b0; shortest = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || en !== 1'b1 || ud !== 1'b0) begin
            failures++;
            $display("FAIL mid_step1: got rdy=%b en=%b ud=%b expected 0 1 0", cmd_ready, en, ud);
        end
        @(negedge clk);
        checks++;
        if (en !== 1'b1 || busy !== 1'b1 || cnt !== 8'd131) begin
            failures++;
            $display("FAIL mid_step2: got en=%b busy=%b cnt=%0d expected 1 1 131", en, busy, cnt);
        end
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, busy, done, en, ud, mismatch} !== 6'b100000 || cnt !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset: got rdy,busy,done,en,ud,mm=%b cnt=%0d expected 100000 0",
                     {cmd_ready, busy, done, en, ud, mismatch}, cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || cnt !== 8'd0) begin
            failures++;
            $display("FAIL mid_after: got rdy=%b busy=%b cnt=%0d expected 1 0 0", cmd_ready, busy, cnt);
        end
    endtask

    initial begin
        test_reset();
        test_linear_up();
        test_shortest_wrap();
        test_clear_first();
        test_tie();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
